// File: rtl/gpia_port_ctl.sv
// gpia_port_ctl: byte-wide GPIA port controller.
// Holds the OUT and DDR registers, synchronises the raw pins, and exposes
// everything over a single-cycle-ack register bus.
// Optional per-bit edge interrupts are built when GPIA_EDGE_IRQ_EN is defined.
module gpia_port_ctl (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       cyc_i,
    input  logic       stb_i,
    input  logic       we_i,
    input  logic [2:0] adr_i,
    input  logic [7:0] dat_i,
    output logic [7:0] dat_o,
    output logic       ack_o,
    input  logic [7:0] pin_i,
    output logic [7:0] out_o,
    output logic [7:0] ddr_o,
    output logic [7:0] inp_o,
    output logic       irq_o
);

    localparam logic [2:0] ADR_OUT  = 3'd0;
    localparam logic [2:0] ADR_DDR  = 3'd1;
    localparam logic [2:0] ADR_IN   = 3'd2;
    localparam logic [2:0] ADR_PEND = 3'd3;
    localparam logic [2:0] ADR_IEN  = 3'd4;
    localparam logic [2:0] ADR_EDGE = 3'd5;

    logic [7:0] out_q, out_d;
    logic [7:0] ddr_q, ddr_d;
    logic [7:0] sync1_q, sync1_d;
    logic [7:0] sync2_q, sync2_d;
    logic [7:0] dat_q, dat_d;
    logic       ack_q, ack_d;

    logic       req;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] in_val;
    logic [7:0] rdata;

`ifdef GPIA_EDGE_IRQ_EN
    logic [7:0] sync3_q, sync3_d;
    logic [7:0] pend_q, pend_d;
    logic [7:0] ien_q, ien_d;
    logic [7:0] edge_q, edge_d;
    logic       irq_q, irq_d;
    logic [7:0] rise_evt;
    logic [7:0] fall_evt;
    logic [7:0] evt;
    logic [7:0] clr;
`endif

    // Two-stage pin synchroniser; sync2 is the value the rest of the block trusts.
    always_comb begin
        sync1_d = pin_i;
        sync2_d = sync1_q;
    end

    // Bus decode: accept only while ack is low so a held strobe alternates ack.
    always_comb begin
        req    = cyc_i & stb_i & ~ack_q;
        wr_en  = req & we_i;
        rd_en  = req & ~we_i;
        ack_d  = req;

        out_d = out_q;
        ddr_d = ddr_q;
        if (wr_en && adr_i == ADR_OUT) out_d = dat_i;
        if (wr_en && adr_i == ADR_DDR) ddr_d = dat_i;

        // Output bits read back the driven value, input bits the synchronised pin.
        in_val = (ddr_q & out_q) | (~ddr_q & sync2_q);

        rdata = 8'h00;
        case (adr_i)
            ADR_OUT:  rdata = out_q;
            ADR_DDR:  rdata = ddr_q;
            ADR_IN:   rdata = in_val;
`ifdef GPIA_EDGE_IRQ_EN
            ADR_PEND: rdata = pend_q;
            ADR_IEN:  rdata = ien_q;
            ADR_EDGE: rdata = edge_q;
`endif
            default:  rdata = 8'h00;
        endcase

        // Read data is captured on acceptance and held until the next read.
        dat_d = rd_en ? rdata : dat_q;
    end

    // Core registers; reset also drops an in-flight ack and discards its write.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            out_q   <= 8'h00;
            ddr_q   <= 8'h00;
            sync1_q <= 8'h00;
            sync2_q <= 8'h00;
            dat_q   <= 8'h00;
            ack_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            ddr_q   <= ddr_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            dat_q   <= dat_d;
            ack_q   <= ack_d;
        end
    end

`ifdef GPIA_EDGE_IRQ_EN
    // Edge detect on sync2 vs sync3; only input bits may raise a pending flag.
    always_comb begin
        sync3_d  = sync2_q;
        rise_evt = sync2_q & ~sync3_q;
        fall_evt = ~sync2_q & sync3_q;
        evt      = ((edge_q & fall_evt) | (~edge_q & rise_evt)) & ~ddr_q;

        clr    = (wr_en && adr_i == ADR_PEND) ? dat_i : 8'h00;
        // A new event beats a write-1-clear on the same bit.
        pend_d = (pend_q & ~clr) | evt;

        ien_d  = (wr_en && adr_i == ADR_IEN)  ? dat_i : ien_q;
        edge_d = (wr_en && adr_i == ADR_EDGE) ? dat_i : edge_q;
        irq_d  = |(pend_q & ien_q);
    end

    // Interrupt state registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync3_q <= 8'h00;
            pend_q  <= 8'h00;
            ien_q   <= 8'h00;
            edge_q  <= 8'h00;
            irq_q   <= 1'b0;
        end else begin
            sync3_q <= sync3_d;
            pend_q  <= pend_d;
            ien_q   <= ien_d;
            edge_q  <= edge_d;
            irq_q   <= irq_d;
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

    assign dat_o = dat_q;
    assign ack_o = ack_q;
    assign out_o = out_q;
    assign ddr_o = ddr_q;
    assign inp_o = sync2_q;

endmodule

// File: tb/tb_gpia_port_ctl.sv
// Self-checking bench for gpia_port_ctl: vector table of bus accesses with a
// read-data scoreboard, plus hand sequences for reset, held strobe and IRQs.
module tb_gpia_port_ctl;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       cyc_i, stb_i, we_i;
    logic [2:0] adr_i;
    logic [7:0] dat_i;
    logic [7:0] dat_o;
    logic       ack_o;
    logic [7:0] pin_i;
    logic [7:0] out_o, ddr_o, inp_o;
    logic       irq_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       is_rd;
        logic [2:0] adr;
        logic [7:0] exp;
    } sb_t;
    sb_t sb[$];
    sb_t mon_e;

    typedef struct {
        logic       we;
        logic [2:0] adr;
        logic [7:0] dat;
        logic [7:0] pin;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[$];

    gpia_port_ctl dut (
        .clk_i(clk_i), .reset_i(reset_i), .cyc_i(cyc_i), .stb_i(stb_i),
        .we_i(we_i), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
        .ack_o(ack_o), .pin_i(pin_i), .out_o(out_o), .ddr_o(ddr_o),
        .inp_o(inp_o), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // One bus access; reads push their expected data to the scoreboard.
    task automatic access(input logic we, input logic [2:0] adr,
                          input logic [7:0] dat, input logic [7:0] exp);
        @(negedge clk_i);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = dat;
        sb.push_back('{is_rd: !we, adr: adr, exp: exp});
        @(negedge clk_i);
        chk($sformatf("ack_adr%0d", adr), {7'b0, ack_o}, 8'h01);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    endtask

    // Scoreboard consumer: every ack retires the oldest outstanding access.
    always @(negedge clk_i) begin
        if (!reset_i && ack_o) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow: got ack with no access outstanding, expected none");
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.is_rd) chk($sformatf("rd_adr%0d", mon_e.adr), dat_o, mon_e.exp);
            end
        end
    end

    initial begin
        reset_i = 1'b1;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; adr_i = 3'd0; dat_i = 8'h00;
        pin_i = 8'h00;
        wait_clk(2);
        chk("rst_ack", {7'b0, ack_o}, 8'h00);
        chk("rst_dat", dat_o, 8'h00);
        chk("rst_out", out_o, 8'h00);
        chk("rst_ddr", ddr_o, 8'h00);
        chk("rst_inp", inp_o, 8'h00);
        chk("rst_irq", {7'b0, irq_o}, 8'h00);
        reset_i = 1'b0;

        // Reset in the middle of a read, then across a pending write.
        access(1'b1, 3'd0, 8'hFF, 8'h00);
        @(negedge clk_i);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 3'd0;
        sb.push_back('{is_rd: 1'b1, adr: 3'd0, exp: 8'hFF});
        @(posedge clk_i); #1;
        chk("ack_before_rst", {7'b0, ack_o}, 8'h01);
        reset_i = 1'b1; #1;
        chk("ack_midrst", {7'b0, ack_o}, 8'h00);
        chk("dat_midrst", dat_o, 8'h00);
        chk("out_midrst", out_o, 8'h00);
        sb.delete();
        @(negedge clk_i);
        we_i = 1'b1; dat_i = 8'h77;
        @(negedge clk_i);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        reset_i = 1'b0;
        chk("out_nowrite", out_o, 8'h00);
        for (int a = 0; a < 8; a++) access(1'b0, a[2:0], 8'h00, 8'h00);

        // Main vector table: {we, adr, dat, pin, expected read data}.
        vecs.push_back('{1'b1, 3'd0, 8'hA5, 8'h00, 8'h00});
        vecs.push_back('{1'b1, 3'd1, 8'h0F, 8'h00, 8'h00});
        vecs.push_back('{1'b0, 3'd2, 8'h00, 8'h3C, 8'h35});
        vecs.push_back('{1'b0, 3'd0, 8'h00, 8'h3C, 8'hA5});
        vecs.push_back('{1'b0, 3'd1, 8'h00, 8'h3C, 8'h0F});
        vecs.push_back('{1'b1, 3'd6, 8'hFF, 8'h3C, 8'h00});
        vecs.push_back('{1'b1, 3'd7, 8'hFF, 8'h3C, 8'h00});
        vecs.push_back('{1'b0, 3'd6, 8'h00, 8'h3C, 8'h00});
        vecs.push_back('{1'b0, 3'd7, 8'h00, 8'h3C, 8'h00});
        vecs.push_back('{1'b0, 3'd0, 8'h00, 8'h3C, 8'hA5});
`ifndef GPIA_EDGE_IRQ_EN
        vecs.push_back('{1'b1, 3'd3, 8'hFF, 8'h3C, 8'h00});
        vecs.push_back('{1'b1, 3'd4, 8'hFF, 8'h3C, 8'h00});
        vecs.push_back('{1'b1, 3'd5, 8'hFF, 8'h3C, 8'h00});
        vecs.push_back('{1'b0, 3'd3, 8'h00, 8'h3C, 8'h00});
        vecs.push_back('{1'b0, 3'd4, 8'h00, 8'h3C, 8'h00});
        vecs.push_back('{1'b0, 3'd5, 8'h00, 8'h3C, 8'h00});
`endif
        vecs.push_back('{1'b1, 3'd0, 8'h5A, 8'hC3, 8'h00});
        vecs.push_back('{1'b1, 3'd1, 8'hF0, 8'hC3, 8'h00});
        vecs.push_back('{1'b0, 3'd2, 8'h00, 8'hC3, 8'h53});
        foreach (vecs[i]) begin
            pin_i = vecs[i].pin;
            wait_clk(3);
            access(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].exp);
        end
        chk("out_o", out_o, 8'h5A);
        chk("ddr_o", ddr_o, 8'hF0);
        chk("inp_o", inp_o, 8'hC3);

        // Held strobe: one read every two cycles.
        @(negedge clk_i);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 3'd0;
        for (int k = 0; k < 3; k++) sb.push_back('{is_rd: 1'b1, adr: 3'd0, exp: 8'h5A});
        chk("held_ack0", {7'b0, ack_o}, 8'h00);
        for (int k = 1; k < 6; k++) begin
            @(negedge clk_i);
            chk($sformatf("held_ack%0d", k), {7'b0, ack_o}, (k % 2 == 1) ? 8'h01 : 8'h00);
        end
        cyc_i = 1'b0; stb_i = 1'b0;
        wait_clk(1);

`ifdef GPIA_EDGE_IRQ_EN
        access(1'b1, 3'd1, 8'h00, 8'h00);
        access(1'b1, 3'd5, 8'h80, 8'h00);
        pin_i = 8'h00;
        wait_clk(4);
        access(1'b1, 3'd3, 8'hFF, 8'h00);
        access(1'b1, 3'd4, 8'h81, 8'h00);
        access(1'b0, 3'd3, 8'h00, 8'h00);
        wait_clk(1);
        chk("irq_cleared", {7'b0, irq_o}, 8'h00);

        // Rising on bit 0, bit 7 watches falling: latency 2/3/4 clocks.
        @(negedge clk_i); pin_i = 8'h81;
        wait_clk(2);
        chk("inp_lat2", inp_o, 8'h81);
        wait_clk(1);
        chk("irq_lat3", {7'b0, irq_o}, 8'h00);
        wait_clk(1);
        chk("irq_lat4", {7'b0, irq_o}, 8'h01);
        access(1'b0, 3'd3, 8'h00, 8'h01);
        pin_i = 8'h00;
        wait_clk(4);
        access(1'b0, 3'd3, 8'h00, 8'h81);
        access(1'b1, 3'd3, 8'h81, 8'h00);
        wait_clk(1);
        chk("irq_after_clr", {7'b0, irq_o}, 8'h00);
        access(1'b0, 3'd3, 8'h00, 8'h00);

        // Output bits never raise events; DDR 1->0 alone is not an event.
        access(1'b1, 3'd1, 8'h01, 8'h00);
        pin_i = 8'h01; wait_clk(4);
        pin_i = 8'h00; wait_clk(4);
        access(1'b1, 3'd1, 8'h00, 8'h00);
        wait_clk(3);
        access(1'b0, 3'd3, 8'h00, 8'h00);

        // Event and write-1-clear land on the same edge: set wins.
        @(negedge clk_i); pin_i = 8'h01;
        @(negedge clk_i);
        access(1'b1, 3'd3, 8'h01, 8'h00);
        wait_clk(1);
        chk("race_irq", {7'b0, irq_o}, 8'h01);
        access(1'b0, 3'd3, 8'h00, 8'h01);

        // PEND is independent of IEN; IEN only gates irq.
        access(1'b1, 3'd4, 8'h00, 8'h00);
        wait_clk(1);
        chk("irq_ien_off", {7'b0, irq_o}, 8'h00);
        access(1'b0, 3'd3, 8'h00, 8'h01);
`else
        for (int k = 0; k < 8; k++) begin
            pin_i = 8'($urandom) ^ pin_i;
            wait_clk(2);
            chk($sformatf("irq_off%0d", k), {7'b0, irq_o}, 8'h00);
        end
`endif

        wait_clk(2);
        chk("sb_drain", 8'(sb.size()), 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
